// File: rtl/mptw_mem_req_arbiter.sv
// Round-robin arbiter sharing the MPT memory read port across NUM_REQ walkers; grant -> slot in 1 cycle, responses routed combinationally.
// Backpressure: the slot holds until mem_req_ready_i; grants stall on flush, a blocked slot or MAX_OUTSTANDING in flight.
module mptw_mem_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 56,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
  input  logic                          mem_req_ready_i,
  input  logic                          mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data_i,
  input  logic                          mem_rsp_err_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  input  logic                          flush_i,
  output logic                          busy_o,
  output logic                          protocol_err_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ID_W:0]    NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            drop;
  } id_ent_t;

  logic                  slot_vld_q;
  logic [ADDR_WIDTH-1:0] slot_addr_q;
  id_ent_t               fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic                  perr_q;

  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [ID_W:0]         scan;
  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_idx;
  logic                  can_grant;
  logic                  grant;
  logic                  fifo_empty;
  logic                  pop;
  id_ent_t               head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign req_addr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scan from rr_ptr_q upward, wrapping at NUM_REQ (which need not be a power of 2).
  always_comb begin
    scan      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (scan >= NUM_REQ_X) scan = scan - NUM_REQ_X;
      if (!gnt_found && req_valid_i[scan[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[ID_W-1:0];
      end
    end
  end

  // Capacity is judged on the registered count: a same-cycle pop does not free a slot.
  assign can_grant  = !flush_i && (!slot_vld_q || mem_req_ready_i) && (count_q < MAX_CNT);
  assign grant      = !rst_i && can_grant && gnt_found;
  assign fifo_empty = (count_q == '0);
  assign pop        = mem_rsp_valid_i && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  assign req_ready_o     = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rsp_valid_o     = (!rst_i && pop && !head.drop) ? (NUM_REQ'(1) << head.id) : '0;
  assign rsp_data_o      = rst_i ? '0 : mem_rsp_data_i;
  assign rsp_err_o       = !rst_i && mem_rsp_err_i;
  assign mem_req_valid_o = slot_vld_q;
  assign mem_req_addr_o  = slot_addr_q;
  assign busy_o          = slot_vld_q || !fifo_empty;
  assign protocol_err_o  = perr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
      perr_q      <= 1'b0;
    end else begin
      if (grant) begin
        slot_vld_q  <= 1'b1;
        slot_addr_q <= req_addr[gnt_idx];
      end else if (mem_req_ready_i) begin
        slot_vld_q  <= 1'b0;
      end

      // Marking every entry is safe: stale entries are overwritten on push, and no push happens under flush.
      if (flush_i) begin
        for (int k = 0; k < MAX_OUTSTANDING; k++) fifo_q[k].drop <= 1'b1;
      end

      if (grant) begin
        fifo_q[wr_ptr_q] <= '{id: gnt_idx, drop: 1'b0};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        rr_ptr_q         <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
      end

      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (grant && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!grant && pop) count_q <= count_q - CNT_W'(1);

      if (mem_rsp_valid_i && fifo_empty) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mptw_mem_req_arbiter.sv
// Bench for mptw_mem_req_arbiter: directed vector table, hand sequences, then randomized traffic against a queue model.
module tb_mptw_mem_req_arbiter;
  localparam int NR = 4;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int MO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR-1:0]   req_ready_o;
  logic            mem_req_valid_o;
  logic [AW-1:0]   mem_req_addr_o;
  logic            mem_req_ready_i;
  logic            mem_rsp_valid_i;
  logic [DW-1:0]   mem_rsp_data_i;
  logic            mem_rsp_err_i;
  logic [NR-1:0]   rsp_valid_o;
  logic [DW-1:0]   rsp_data_o;
  logic            rsp_err_o;
  logic            flush_i;
  logic            busy_o;
  logic            protocol_err_o;

  always #5 clk_i = ~clk_i;

  mptw_mem_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_err_i(mem_rsp_err_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .flush_i(flush_i), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] rv;
    bit         mr;
    bit         sv;
    logic [7:0] sd;
    bit         se;
    bit         fl;
    logic [3:0] e_rdy;
    bit         e_mv;
    logic [15:0] e_addr;
    logic [3:0] e_rsp;
    bit         e_busy;
    bit         e_perr;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] rv, bit mr, bit sv, logic [7:0] sd, bit se, bit fl,
                              logic [3:0] e_rdy, bit e_mv, logic [15:0] e_addr, logic [3:0] e_rsp,
                              bit e_busy, bit e_perr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.mr = mr; v.sv = sv; v.sd = sd; v.se = se; v.fl = fl;
    v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_addr = e_addr; v.e_rsp = e_rsp; v.e_busy = e_busy; v.e_perr = e_perr;
    return v;
  endfunction

  // Drives one cycle of inputs, checks just after the falling edge, then advances one clock.
  task automatic run_vec(input vec_t v, input string tag);
    rst_i = v.rst; req_valid_i = v.rv; mem_req_ready_i = v.mr; mem_rsp_valid_i = v.sv;
    mem_rsp_data_i = 64'(v.sd); mem_rsp_err_i = v.se; flush_i = v.fl;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready_o), 64'(v.e_rdy));
    chk({tag, " mem_req_valid"}, 64'(mem_req_valid_o), 64'(v.e_mv));
    if (v.e_mv) chk({tag, " mem_req_addr"}, 64'(mem_req_addr_o), 64'(v.e_addr));
    chk({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'(v.e_rsp));
    if (v.e_rsp != 0) begin
      chk({tag, " rsp_data"}, 64'(rsp_data_o), 64'(v.sd));
      chk({tag, " rsp_err"}, 64'(rsp_err_o), 64'(v.se));
    end
    chk({tag, " busy"}, 64'(busy_o), 64'(v.e_busy));
    chk({tag, " protocol_err"}, 64'(protocol_err_o), 64'(v.e_perr));
    @(negedge clk_i);
  endtask

  typedef struct {
    int id;
    bit drop;
  } ent_t;

  vec_t          tbl[$];
  ent_t          mq[$];
  bit            m_slot;
  logic [AW-1:0] m_addr;
  int            m_rr;
  bit            m_perr;
  int            mem_pend;

  initial begin
    rst_i = 1'b1; req_valid_i = '0; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i = '0; mem_rsp_err_i = 1'b0; flush_i = 1'b0;
    req_addr_i[0*AW +: AW] = AW'(56'h40);
    req_addr_i[1*AW +: AW] = AW'(56'h1000);
    req_addr_i[2*AW +: AW] = AW'(56'h2000);
    req_addr_i[3*AW +: AW] = AW'(56'h3000);

    // rst rv mr sv sd se fl | rdy mv addr rsp busy perr
    tbl.push_back(mk(1, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0));
    // single request
    tbl.push_back(mk(0, 4'b0010, 1, 0, 8'h00, 0, 0, 4'b0010, 0, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h1000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'hAB, 0, 0, 4'b0000, 0, 16'h0000, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0));
    // fairness from rr pointer 0
    tbl.push_back(mk(1, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0001, 0, 16'h0000, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0010, 1, 16'h0040, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0100, 1, 16'h1000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b1000, 1, 16'h2000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h3000, 4'b0000, 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b1111, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h10, 0, 0, 4'b0000, 0, 16'h0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h11, 0, 0, 4'b0000, 0, 16'h0000, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h12, 1, 0, 4'b0000, 0, 16'h0000, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h13, 0, 0, 4'b0000, 0, 16'h0000, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0));
    // capacity edge: fill to 4, then pop and request together
    tbl.push_back(mk(0, 4'b0001, 1, 0, 8'h00, 0, 0, 4'b0001, 0, 16'h0000, 4'b0000, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b0001, 1, 0, 8'h00, 0, 0, 4'b0001, 1, 16'h0040, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 1, 8'h20, 0, 0, 4'b0000, 1, 16'h0040, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 8'h00, 0, 0, 4'b0001, 0, 16'h0000, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h21, 0, 0, 4'b0000, 1, 16'h0040, 4'b0001, 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h22, 0, 0, 4'b0000, 0, 16'h0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0));
    // backpressure: slot held 5 cycles, then back-to-back refill
    tbl.push_back(mk(0, 4'b0001, 0, 0, 8'h00, 0, 0, 4'b0001, 0, 16'h0000, 4'b0000, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 4'b0001, 0, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h0040, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 8'h00, 0, 0, 4'b0001, 1, 16'h0040, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h0040, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h30, 0, 0, 4'b0000, 0, 16'h0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 8'h31, 0, 0, 4'b0000, 0, 16'h0000, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0));

    repeat (2) @(negedge clk_i);
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("row%0d", i));

    // flush: 3 reads in memory plus an unaccepted slot, all responses dropped
    run_vec(mk(0, 4'b0111, 1, 0, 8'h00, 0, 0, 4'b0010, 0, 16'h0000, 4'b0000, 0, 0), "flush1");
    run_vec(mk(0, 4'b0111, 1, 0, 8'h00, 0, 0, 4'b0100, 1, 16'h1000, 4'b0000, 1, 0), "flush2");
    run_vec(mk(0, 4'b0111, 1, 0, 8'h00, 0, 0, 4'b0001, 1, 16'h2000, 4'b0000, 1, 0), "flush3");
    run_vec(mk(0, 4'b0111, 1, 0, 8'h00, 0, 0, 4'b0010, 1, 16'h0040, 4'b0000, 1, 0), "flush4");
    run_vec(mk(0, 4'b0111, 0, 0, 8'h00, 0, 1, 4'b0000, 1, 16'h1000, 4'b0000, 1, 0), "flush5");
    run_vec(mk(0, 4'b0111, 0, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h1000, 4'b0000, 1, 0), "flush6");
    run_vec(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h1000, 4'b0000, 1, 0), "flush7");
    for (int k = 0; k < 4; k++)
      run_vec(mk(0, 4'b0000, 1, 1, 8'h60, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 1, 0), $sformatf("flush_rsp%0d", k));
    run_vec(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0), "flush_idle");
    run_vec(mk(0, 4'b0100, 1, 0, 8'h00, 0, 0, 4'b0100, 0, 16'h0000, 4'b0000, 0, 0), "post1");
    run_vec(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h2000, 4'b0000, 1, 0), "post2");
    run_vec(mk(0, 4'b0000, 1, 1, 8'h5A, 0, 0, 4'b0000, 0, 16'h0000, 4'b0100, 1, 0), "post3");
    run_vec(mk(0, 4'b0001, 1, 0, 8'h00, 0, 1, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0), "flush_blocks");
    run_vec(mk(0, 4'b0000, 1, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0), "post4");

    // protocol error, then reset with an occupied slot
    run_vec(mk(0, 4'b0000, 1, 1, 8'h77, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0), "perr1");
    run_vec(mk(0, 4'b0001, 0, 0, 8'h00, 0, 0, 4'b0001, 0, 16'h0000, 4'b0000, 0, 1), "perr2");
    run_vec(mk(1, 4'b0000, 0, 0, 8'h00, 0, 0, 4'b0000, 1, 16'h0040, 4'b0000, 1, 1), "rst1");
    run_vec(mk(0, 4'b0000, 0, 0, 8'h00, 0, 0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 0), "rst2");

    // randomized traffic against a queue-based model
    m_slot = 0; m_addr = '0; m_rr = 0; m_perr = 0; mem_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      logic [NR-1:0] e_rdy;
      logic [NR-1:0] e_rsp;
      rst_i           = (cyc == 0) || ($urandom_range(0, 299) == 0);
      req_valid_i     = NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) req_addr_i[i*AW +: AW] = AW'({$urandom, $urandom});
      mem_req_ready_i = ($urandom_range(0, 9) < 7);
      flush_i         = ($urandom_range(0, 39) == 0);
      mem_rsp_valid_i = (mem_pend > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 499) == 0);
      mem_rsp_data_i  = {$urandom, $urandom};
      mem_rsp_err_i   = 1'($urandom_range(0, 1));

      g = -1;
      if (!rst_i && !flush_i && (!m_slot || mem_req_ready_i) && mq.size() < MO) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid_i[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        end
      end
      e_rdy = (g >= 0) ? NR'(1 << g) : '0;
      e_rsp = (!rst_i && mem_rsp_valid_i && mq.size() > 0 && !mq[0].drop) ? NR'(1 << mq[0].id) : '0;

      #1;
      chk("rnd req_ready", 64'(req_ready_o), 64'(e_rdy));
      chk("rnd rsp_valid", 64'(rsp_valid_o), 64'(e_rsp));
      if (e_rsp != 0) begin
        chk("rnd rsp_data", 64'(rsp_data_o), 64'(mem_rsp_data_i));
        chk("rnd rsp_err", 64'(rsp_err_o), 64'(mem_rsp_err_i));
      end
      if (cyc > 0) begin
        chk("rnd mem_req_valid", 64'(mem_req_valid_o), 64'(m_slot));
        if (m_slot) chk("rnd mem_req_addr", 64'(mem_req_addr_o), 64'(m_addr));
        chk("rnd busy", 64'(busy_o), 64'(m_slot || mq.size() != 0));
        chk("rnd protocol_err", 64'(protocol_err_o), 64'(m_perr));
      end

      @(posedge clk_i);
      if (rst_i) begin
        mq.delete(); m_slot = 0; m_addr = '0; m_rr = 0; m_perr = 0; mem_pend = 0;
      end else begin
        if (mem_rsp_valid_i) begin
          if (mem_pend > 0) mem_pend--;
          if (mq.size() > 0) void'(mq.pop_front());
          else m_perr = 1;
        end
        if (m_slot && mem_req_ready_i) mem_pend++;
        if (flush_i) foreach (mq[k]) mq[k].drop = 1;
        if (g >= 0) begin
          mq.push_back('{id: g, drop: 0});
          m_slot = 1;
          m_addr = req_addr_i[g*AW +: AW];
          m_rr   = (g + 1) % NR;
        end else if (mem_req_ready_i) begin
          m_slot = 0;
        end
      end
      @(negedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
